// File: rtl/swap_pkg.sv
// swap_pkg: shared constants, FSM encoding, register reset values and the
// request record for the swap scheduler.
package swap_pkg;
  localparam int DW   = 6;
  localparam int NREG = 4;
  localparam int AW   = 2;

  // FSM encoding
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] S1   = 2'd1;
  localparam logic [1:0] S2   = 2'd2;
  localparam logic [1:0] S3   = 2'd3;

  // register-file reset contents
  localparam int R0_RST = 1;
  localparam int R1_RST = 2;
  localparam int R2_RST = 3;
  localparam int R3_RST = 4;

  function automatic int reg_rst_val(input int idx);
    case (idx)
      0:       return R0_RST;
      1:       return R1_RST;
      2:       return R2_RST;
      3:       return R3_RST;
      default: return 0;
    endcase
  endfunction

  // one requester's swap request
  typedef struct packed {
    logic          req;
    logic [AW-1:0] a;
    logic [AW-1:0] b;
  } swap_req_t;
endpackage

// File: rtl/swap_sched_if.sv
// swap_sched_if: bundles the requester handshakes and the observation port.
//   master: requester side (drives req/addresses, rd_addr; sees acks, idle, rd_data)
//   slave : scheduler side
interface swap_sched_if #(
  parameter int DW = swap_pkg::DW
) ();
  logic                   req0, req1;
  logic [swap_pkg::AW-1:0] a0, b0, a1, b1;
  logic                   ack0, ack1, idle;
  logic [swap_pkg::AW-1:0] rd_addr;
  logic [DW-1:0]          rd_data;

  modport master (
    output req0, a0, b0, req1, a1, b1, rd_addr,
    input  ack0, ack1, idle, rd_data
  );

  modport slave (
    input  req0, a0, b0, req1, a1, b1, rd_addr,
    output ack0, ack1, idle, rd_data
  );
endinterface

// File: rtl/swap_sched_rr_arb2.sv
// rr_arb2: two-way round-robin grant.
//   req[1:0] : request vector
//   last     : index of the most recently granted requester
//   gnt[1:0] : one-hot grant (zero when nothing requests)
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);
  always_comb begin
    gnt = req;
    // on a tie, favour whoever was not served last
    if (req == 2'b11) gnt = last ? 2'b01 : 2'b10;
  end
endmodule

// File: rtl/swap_sched.sv
// swap_sched: arbitrates two requesters and swaps two entries of a small
// register file through a tmp register in three steps (S1, S2, S3).
//   ck, rst        : clock, async active-low reset
//   reqN, aN, bN   : requester N swap request (level) and register pair
//   ackN           : one-cycle completion pulse, high while in S3
//   idle           : FSM is in IDLE
//   rd_addr/rd_data: combinational observation of R[rd_addr]
module swap_sched #(
  parameter int DW   = swap_pkg::DW,
  parameter int NREG = swap_pkg::NREG
) (
  input  logic                    ck,
  input  logic                    rst,
  input  logic                    req0,
  input  logic [swap_pkg::AW-1:0] a0,
  input  logic [swap_pkg::AW-1:0] b0,
  input  logic                    req1,
  input  logic [swap_pkg::AW-1:0] a1,
  input  logic [swap_pkg::AW-1:0] b1,
  output logic                    ack0,
  output logic                    ack1,
  output logic                    idle,
  input  logic [swap_pkg::AW-1:0] rd_addr,
  output logic [DW-1:0]           rd_data
);
  import swap_pkg::*;

  swap_req_t [1:0] rq;
  logic      [1:0] gnt;

  logic [1:0]                state_q, state_d;
  logic [NREG-1:0][DW-1:0]   r_q, r_d;
  logic [DW-1:0]             tmp_q, tmp_d;
  logic                      owner_q, owner_d;
  logic [AW-1:0]             la_q, la_d, lb_q, lb_d;
  logic                      last_q, last_d;

  assign rq[0] = {req0, a0, b0};
  assign rq[1] = {req1, a1, b1};

  rr_arb2 u_arb (
    .req  ({rq[1].req, rq[0].req}),
    .last (last_q),
    .gnt  (gnt)
  );

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    tmp_d   = tmp_q;
    owner_d = owner_q;
    la_d    = la_q;
    lb_d    = lb_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        // requests are only looked at here; addresses are frozen at grant
        if (|gnt) begin
          state_d = S1;
          owner_d = gnt[1];
          la_d    = rq[gnt[1]].a;
          lb_d    = rq[gnt[1]].b;
          last_d  = gnt[1];
        end
      end
      S1: begin
        tmp_d   = r_q[la_q];
        state_d = S2;
      end
      S2: begin
        r_d[la_q] = r_q[lb_q];
        state_d   = S3;
      end
      S3: begin
        r_d[lb_q] = tmp_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      for (int i = 0; i < NREG; i++) r_q[i] <= DW'(reg_rst_val(i));
      tmp_q   <= '0;
      owner_q <= 1'b0;
      la_q    <= '0;
      lb_q    <= '0;
      last_q  <= 1'b1;  // first tie after reset goes to requester 0
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      tmp_q   <= tmp_d;
      owner_q <= owner_d;
      la_q    <= la_d;
      lb_q    <= lb_d;
      last_q  <= last_d;
    end
  end

  assign ack0    = (state_q == S3) && !owner_q;
  assign ack1    = (state_q == S3) &&  owner_q;
  assign idle    = (state_q == IDLE);
  assign rd_data = r_q[rd_addr];
endmodule

// File: tb/tb_swap_sched.sv
module tb_swap_sched;
  localparam int DW = 6;

  typedef logic [3:0][DW-1:0] regs_t;

  typedef struct {
    logic       rst_n;
    logic       r0;
    logic [1:0] a0, b0;
    logic       r1;
    logic [1:0] a1, b1;
    logic       e_ack0, e_ack1, e_idle;
    regs_t      e_r;
  } vec_t;

  logic ck, rst_n;
  swap_sched_if #(.DW(DW)) sif ();

  swap_sched #(.DW(DW), .NREG(4)) dut (
    .ck(ck), .rst(rst_n),
    .req0(sif.req0), .a0(sif.a0), .b0(sif.b0),
    .req1(sif.req1), .a1(sif.a1), .b1(sif.b1),
    .ack0(sif.ack0), .ack1(sif.ack1), .idle(sif.idle),
    .rd_addr(sif.rd_addr), .rd_data(sif.rd_data)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  int nvec = 0;
  int nfail = 0;
  vec_t tbl[$];

  function automatic regs_t rv(int v0, int v1, int v2, int v3);
    regs_t r;
    r[0] = DW'(v0); r[1] = DW'(v1); r[2] = DW'(v2); r[3] = DW'(v3);
    return r;
  endfunction

  function automatic vec_t mk(logic rs, logic r0, int a0, int b0, logic r1, int a1, int b1,
                              logic k0, logic k1, logic id, regs_t r);
    vec_t v;
    v.rst_n = rs; v.r0 = r0; v.a0 = 2'(a0); v.b0 = 2'(b0);
    v.r1 = r1; v.a1 = 2'(a1); v.b1 = 2'(b1);
    v.e_ack0 = k0; v.e_ack1 = k1; v.e_idle = id; v.e_r = r;
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(logic rs, logic r0, int a0, int b0, logic r1, int a1, int b1);
    rst_n = rs;
    sif.req0 = r0; sif.a0 = 2'(a0); sif.b0 = 2'(b0);
    sif.req1 = r1; sif.a1 = 2'(a1); sif.b1 = 2'(b1);
  endtask

  task automatic check_out(string tag, logic k0, logic k1, logic id);
    #1;
    chk({tag, " ack0"}, int'(sif.ack0), int'(k0));
    chk({tag, " ack1"}, int'(sif.ack1), int'(k1));
    chk({tag, " idle"}, int'(sif.idle), int'(id));
  endtask

  task automatic check_r(string tag, regs_t er);
    for (int i = 0; i < 4; i++) begin
      sif.rd_addr = 2'(i);
      #1;
      chk($sformatf("%s R%0d", tag, i), int'(sif.rd_data), int'(er[i]));
    end
  endtask

  task automatic step();
    @(posedge ck);
    #1;
  endtask

  initial begin
    drive(1'b0, 0, 0, 0, 0, 0, 0);
    sif.rd_addr = '0;

    // swap (0,2) by requester 0
    tbl.push_back(mk(0, 0,0,0, 0,0,0, 0,0,1, rv(1,2,3,4)));
    tbl.push_back(mk(1, 1,0,2, 0,0,0, 0,0,1, rv(1,2,3,4)));
    tbl.push_back(mk(1, 1,0,2, 0,0,0, 0,0,0, rv(1,2,3,4)));
    tbl.push_back(mk(1, 1,0,2, 0,0,0, 0,0,0, rv(1,2,3,4)));
    tbl.push_back(mk(1, 1,0,2, 0,0,0, 1,0,0, rv(3,2,3,4)));
    tbl.push_back(mk(1, 0,0,2, 0,0,0, 0,0,1, rv(3,2,1,4)));
    tbl.push_back(mk(1, 0,0,2, 0,0,0, 0,0,1, rv(3,2,1,4)));
    // simultaneous requests after reset: 0 wins the tie, 1 follows
    tbl.push_back(mk(0, 0,0,0, 0,0,0, 0,0,1, rv(1,2,3,4)));
    tbl.push_back(mk(1, 1,0,1, 1,2,3, 0,0,1, rv(1,2,3,4)));
    tbl.push_back(mk(1, 1,0,1, 1,2,3, 0,0,0, rv(1,2,3,4)));
    tbl.push_back(mk(1, 1,0,1, 1,2,3, 0,0,0, rv(1,2,3,4)));
    tbl.push_back(mk(1, 1,0,1, 1,2,3, 1,0,0, rv(2,2,3,4)));
    tbl.push_back(mk(1, 0,0,1, 1,2,3, 0,0,1, rv(2,1,3,4)));
    tbl.push_back(mk(1, 0,0,1, 1,2,3, 0,0,0, rv(2,1,3,4)));
    tbl.push_back(mk(1, 0,0,1, 1,2,3, 0,0,0, rv(2,1,3,4)));
    tbl.push_back(mk(1, 0,0,1, 1,2,3, 0,1,0, rv(2,1,4,4)));
    tbl.push_back(mk(1, 0,0,1, 0,2,3, 0,0,1, rv(2,1,4,3)));
    tbl.push_back(mk(1, 0,0,1, 0,2,3, 0,0,1, rv(2,1,4,3)));
    // self-swap: full sequence, R unchanged
    tbl.push_back(mk(0, 0,0,0, 0,0,0, 0,0,1, rv(1,2,3,4)));
    tbl.push_back(mk(1, 0,0,0, 1,3,3, 0,0,1, rv(1,2,3,4)));
    tbl.push_back(mk(1, 0,0,0, 1,3,3, 0,0,0, rv(1,2,3,4)));
    tbl.push_back(mk(1, 0,0,0, 1,3,3, 0,0,0, rv(1,2,3,4)));
    tbl.push_back(mk(1, 0,0,0, 1,3,3, 0,1,0, rv(1,2,3,4)));
    tbl.push_back(mk(1, 0,0,0, 0,3,3, 0,0,1, rv(1,2,3,4)));
    // req dropped and address changed after grant
    tbl.push_back(mk(0, 0,0,0, 0,0,0, 0,0,1, rv(1,2,3,4)));
    tbl.push_back(mk(1, 1,1,2, 0,0,0, 0,0,1, rv(1,2,3,4)));
    tbl.push_back(mk(1, 0,3,2, 0,0,0, 0,0,0, rv(1,2,3,4)));
    tbl.push_back(mk(1, 0,3,2, 0,0,0, 0,0,0, rv(1,2,3,4)));
    tbl.push_back(mk(1, 0,3,2, 0,0,0, 1,0,0, rv(1,3,3,4)));
    tbl.push_back(mk(1, 0,3,2, 0,0,0, 0,0,1, rv(1,3,2,4)));
    tbl.push_back(mk(1, 0,3,2, 0,0,0, 0,0,1, rv(1,3,2,4)));

    step();
    foreach (tbl[k]) begin
      string tag;
      tag = $sformatf("row%0d", k);
      drive(tbl[k].rst_n, tbl[k].r0, int'(tbl[k].a0), int'(tbl[k].b0),
            tbl[k].r1, int'(tbl[k].a1), int'(tbl[k].b1));
      check_out(tag, tbl[k].e_ack0, tbl[k].e_ack1, tbl[k].e_idle);
      check_r(tag, tbl[k].e_r);
      step();
    end

    // reset during S2: abort, no ack
    drive(0, 0,0,0, 0,0,0);
    step();
    drive(1, 1,0,1, 0,0,0);
    check_out("rs2 c0", 0, 0, 1);
    step();
    check_out("rs2 c1", 0, 0, 0);
    step();
    check_out("rs2 c2", 0, 0, 0);
    drive(0, 0,0,1, 0,0,0);
    check_out("rs2 abort", 0, 0, 1);
    check_r("rs2 abort", rv(1,2,3,4));
    step();
    drive(1, 0,0,1, 0,0,0);
    for (int c = 0; c < 5; c++) begin
      check_out($sformatf("rs2 post%0d", c), 0, 0, 1);
      step();
    end
    check_r("rs2 post", rv(1,2,3,4));

    // reset during S3: the partial write to R[0] is undone
    drive(1, 1,0,1, 0,0,0);
    step(); step(); step();
    check_out("rs3 c3", 1, 0, 0);
    check_r("rs3 c3", rv(2,2,3,4));
    drive(0, 0,0,1, 0,0,0);
    check_out("rs3 abort", 0, 0, 1);
    check_r("rs3 abort", rv(1,2,3,4));
    step();

    // both requests held: grants alternate, one op every 4 cycles
    drive(1, 1,0,1, 1,2,3);
    for (int c = 0; c < 16; c++) begin
      check_out($sformatf("rr c%0d", c), logic'(c % 8 == 3), logic'(c % 8 == 7),
                logic'(c % 4 == 0));
      step();
    end
    check_r("rr end", rv(1,2,3,4));
    drive(1, 0,0,1, 0,2,3);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule

// File: doc/swap_sched.md
SWAP_SCHED -- requirements
Module: swap_sched

Interface
REQ-001 The module SHALL expose the following ports:
- ck  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req0  in  1  requester 0 swap request, level, held until ack0.
- a0  in  2  requester 0 first register address.
- b0  in  2  requester 0 second register address.
- req1  in  1  requester 1 swap request, level, held until ack1.
- a1  in  2  requester 1 first register address.
- b1  in  2  requester 1 second register address.
- ack0  out  1  requester 0 completion pulse.
- ack1  out  1  requester 1 completion pulse.
- idle  out  1  high when the FSM is in IDLE.
- rd_addr  in  2  observation read address.
- rd_data  out  6  combinational contents of R[rd_addr].

REQ-002 The module SHALL have the following parameters:
- DW, default 6, register width.
- NREG, default 4, register count.

Function
REQ-003 The module SHALL own a register file R[0..3] of DW bits, a DW-bit tmp register, an owner bit, latched addresses la and lb, and a round-robin pointer last.
REQ-004 The FSM SHALL have states IDLE, S1, S2 and S3, and SHALL ignore new requests outside IDLE.
REQ-005 In IDLE with at least one req high, the next edge SHALL go to S1, set owner to the granted requester, and latch that requester's a and b into la and lb.
REQ-006 With a single req high in IDLE, that requester SHALL be granted.
REQ-007 With both reqs high in IDLE, the requester other than last SHALL be granted, and last SHALL update to the granted requester on the grant edge.
REQ-008 At the S1 to S2 edge the module SHALL perform tmp <= R[la].
REQ-009 At the S2 to S3 edge the module SHALL perform R[la] <= R[lb].
REQ-010 At the S3 to IDLE edge the module SHALL perform R[lb] <= tmp.
REQ-011 ack_owner SHALL be high for exactly the one cycle the FSM is in S3; the other ack SHALL stay low.
REQ-012 The request-to-ack latency SHALL be 3 cycles: req sampled in IDLE in cycle n gives ack in cycle n+3, and the swapped values are visible in cycle n+4.
REQ-013 Back-to-back operations SHALL spend at least one cycle in IDLE between S3 and the next S1, giving a 4-cycle minimum period.
REQ-014 Changes to a0, a1, b0 or b1 after the grant edge SHALL have no effect on the operation in progress.
REQ-015 If the owner deasserts req after the grant, the operation SHALL still complete and ack SHALL still pulse.
REQ-016 The requester SHALL drop req in the cycle after ack; a req still high in IDLE SHALL be treated as a new request.
REQ-017 When la equals lb, the full 3-step sequence SHALL run and ack SHALL pulse, with R left unchanged.
REQ-018 idle SHALL equal (state == IDLE).
REQ-019 rd_data SHALL read the current register value, not bypassing a write on the same edge.

Reset
REQ-020 While rst is low, asynchronously, the module SHALL force: state = IDLE, R[0..3] = 1, 2, 3, 4, tmp = 0, owner = 0, la = lb = 0, last = 1.
REQ-021 During reset, ack0 and ack1 SHALL be low and idle SHALL be high.
REQ-022 A reset in any of S1, S2 or S3 SHALL abort the operation with no ack and restore the reset register values.
REQ-023 After reset is released, the first tie SHALL be granted to requester 0.

Structure
REQ-024 A shared package swap_pkg SHALL hold the state encoding (IDLE=0, S1=1, S2=2, S3=3) and the constants DW, NREG and AW=2.
REQ-025 swap_pkg SHALL also hold the register reset values 1, 2, 3 and 4.
REQ-026 Two-way round-robin grant logic SHALL be a sub-module rr_arb2 with inputs req[1:0] and last, and a one-hot output gnt[1:0].
REQ-027 The FSM, datapath and ack logic SHALL remain in swap_sched.

Verification
REQ-028 Bench: reset, then req0 with a0=0, b0=2 -> ack0 in cycle 3, then R = 3, 2, 1, 4 and idle=1.
REQ-029 Bench: req0 (0,1) and req1 (2,3) asserted together after reset -> ack0 in cycle 3, ack1 in cycle 7, final R = 2, 1, 4, 3.
REQ-030 Bench: req1 with a1=b1=3 -> ack1 in cycle 3 and R unchanged at 1, 2, 3, 4.
REQ-031 Bench: req0 (0,1) with rst pulsed low during S2 -> no ack, R = 1, 2, 3, 4, idle=1 immediately.
REQ-032 Bench: req0 (1,2) dropped in S1 while a0 changes to 3 -> ack0 still pulses and R = 1, 3, 2, 4.
REQ-033 Bench: req0 and req1 held high continuously -> grants alternate 0, 1, 0, 1 with acks every 4 cycles.
